m_fetch_unit: RTL and testbench



---
 rtl/m_cpu_pkg.sv | 16 +
 rtl/m_fetch_fifo.sv | 80 ++++++++
 rtl/m_fetch_unit_chk.sv | 19 +
 rtl/m_fetch_unit.sv | 122 ++++++++++++
 tb/tb_m_fetch_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/m_cpu_pkg.sv
// Shared CPU front-end constants and PC helpers.
package m_cpu_pkg;

  localparam int unsigned       XLEN             = 32;
  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0]   INST_BYTES       = 32'd4;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// In-order {pc, inst} queue between fetch and decode; flush wins over push/pop,
// data output reads as zero while empty.
module m_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_s;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_s    = pop_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/m_fetch_unit_chk.sv
// Protocol checks on the instruction-memory handshake seen by the fetch unit.
module m_fetch_unit_chk #(
  parameter int unsigned CW = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          req_i,
  input logic          gnt_i,
  input logic          rvalid_i,
  input logic [CW-1:0] outst_i
);

  a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    gnt_i |-> req_i);

  a_rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> (outst_i != '0));

endmodule

// File: rtl/m_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited sequential requests,
// discards responses made stale by a redirect and queues the rest for decode.
module m_fetch_unit
  import m_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr,
  input  logic        w_imem_gnt,
  input  logic        w_imem_rvalid,
  input  logic [31:0] w_imem_rdata,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_id_valid,
  output logic [31:0] w_id_inst,
  output logic [31:0] w_id_pc,
  input  logic        w_id_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          active_q;

  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   credit_used_s;
  logic          req_s;
  logic          fire_s;
  logic          keep_s;

  // Credits cover both in-flight and buffered work, so the queue cannot overflow.
  // active_q keeps req low for the first cycle after reset.
  assign credit_used_s = {1'b0, outst_q} + {1'b0, fifo_count_s};
  assign req_s  = active_q && !w_redirect && (credit_used_s < (CW+1)'(DEPTH));
  assign fire_s = req_s && w_imem_gnt;
  assign keep_s = w_imem_rvalid && (drop_q == '0) && !w_redirect;

  // PC, credit and stale-response bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (w_redirect) begin
      fetch_pc_d = align_pc(w_redirect_pc);
      resp_pc_d  = align_pc(w_redirect_pc);
      outst_d    = outst_q - CW'(w_imem_rvalid);
      drop_d     = outst_q - CW'(w_imem_rvalid);
    end else begin
      outst_d = outst_q + CW'(fire_s) - CW'(w_imem_rvalid);
      if (fire_s) begin
        fetch_pc_d = next_pc(fetch_pc_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (w_imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
      if (keep_s) begin
        resp_pc_d = next_pc(resp_pc_q);
      end else begin
        resp_pc_d = resp_pc_q;
      end
    end
  end

  // Fetch state register.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      active_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      active_q   <= 1'b1;
    end
  end

  m_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i   (w_clk),
    .rst_ni  (w_rst_n),
    .flush_i (w_redirect),
    .push_i  (keep_s),
    .data_i  ({resp_pc_q, w_imem_rdata}),
    .pop_i   (w_id_ready && !w_redirect),
    .valid_o (w_id_valid),
    .data_o  ({w_id_pc, w_id_inst}),
    .count_o (fifo_count_s)
  );

  m_fetch_unit_chk #(
    .CW (CW)
  ) u_chk (
    .clk_i    (w_clk),
    .rst_ni   (w_rst_n),
    .req_i    (req_s),
    .gnt_i    (w_imem_gnt),
    .rvalid_i (w_imem_rvalid),
    .outst_i  (outst_q)
  );

  assign w_imem_req  = req_s;
  assign w_imem_addr = fetch_pc_q;

endmodule

// File: tb/tb_m_fetch_unit.sv
// Randomized bench for m_fetch_unit: an in-order memory with random latency and a
// request-level reference model that tags each in-flight request as live or stale.
module tb_m_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NCYC   = 4800;

  logic        w_clk = 1'b1;
  logic        w_rst_n;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_gnt;
  logic        w_imem_rvalid;
  logic [31:0] w_imem_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_id_valid;
  logic [31:0] w_id_inst;
  logic [31:0] w_id_pc;
  logic        w_id_ready;

  m_fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .w_imem_req    (w_imem_req),
    .w_imem_addr   (w_imem_addr),
    .w_imem_gnt    (w_imem_gnt),
    .w_imem_rvalid (w_imem_rvalid),
    .w_imem_rdata  (w_imem_rdata),
    .w_redirect    (w_redirect),
    .w_redirect_pc (w_redirect_pc),
    .w_id_valid    (w_id_valid),
    .w_id_inst     (w_id_inst),
    .w_id_pc       (w_id_pc),
    .w_id_ready    (w_id_ready)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] mq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA000_0001;
  endfunction

  initial begin
    logic        m_active;
    logic [31:0] m_fetch_pc;
    logic [63:0] head;
    logic [31:0] rpc;
    int          last_due;
    int          mode;
    int          lat;
    int          due;
    bit          rst;
    bit          redir;
    bit          rv;
    bit          rdy;
    bit          gnt;
    bit          m_req;
    bit          do_pop;
    pend_t       e;

    m_active      = 1'b0;
    m_fetch_pc    = RST_PC;
    last_due      = 0;
    w_rst_n       = 1'b0;
    w_imem_gnt    = 1'b0;
    w_imem_rvalid = 1'b0;
    w_imem_rdata  = 32'h0;
    w_redirect    = 1'b0;
    w_redirect_pc = 32'h0;
    w_id_ready    = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge w_clk);
      mode = (cyc / 400) % 6;

      rst   = (cyc < 2) || ((mode == 5) && ($urandom_range(0, 99) < 2));
      redir = !rst && (mode >= 3) &&
              ($urandom_range(0, 99) < ((mode == 4) ? 25 : 10));
      if ((mode == 4) && ($urandom_range(0, 1) == 1)) begin
        rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else begin
        rpc = $urandom();
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 40) >= 20);
        default: rdy = ($urandom_range(0, 99) < 70);
      endcase
      rv = !rst && (pend.size() > 0) && (pend[0].due <= cyc);

      w_rst_n       = !rst;
      w_redirect    = redir;
      w_redirect_pc = rpc;
      w_id_ready    = rdy;
      w_imem_rvalid = rv;
      w_imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom();
      #1;

      m_req = m_active && !redir && ((pend.size() + mq.size()) < DEPTH);
      head  = (mq.size() > 0) ? mq[0] : 64'h0;
      if (cyc > 0) begin
        check_eq("imem_req",  {31'b0, w_imem_req}, {31'b0, m_req});
        check_eq("imem_addr", w_imem_addr, m_fetch_pc);
        check_eq("id_valid",  {31'b0, w_id_valid}, {31'b0, (mq.size() > 0)});
        check_eq("id_pc",     w_id_pc, head[63:32]);
        check_eq("id_inst",   w_id_inst, head[31:0]);
      end

      case (mode)
        0, 1:    gnt = m_req;
        2:       gnt = m_req && ($urandom_range(0, 99) < 30);
        default: gnt = m_req && ($urandom_range(0, 99) < 60);
      endcase
      if (rst) begin
        gnt = 1'b0;
      end
      w_imem_gnt = gnt;

      if (rst) begin
        pend.delete();
        mq.delete();
        m_active   = 1'b0;
        m_fetch_pc = RST_PC;
        last_due   = 0;
      end else begin
        m_active = 1'b1;
        if (redir) begin
          if (rv) begin
            void'(pend.pop_front());
          end
          for (int i = 0; i < pend.size(); i++) begin
            e       = pend[i];
            e.stale = 1'b1;
            pend[i] = e;
          end
          mq.delete();
          m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
          do_pop = rdy && (mq.size() > 0);
          if (do_pop) begin
            void'(mq.pop_front());
          end
          if (rv) begin
            e = pend.pop_front();
            if (!e.stale) begin
              mq.push_back({e.addr, mem_word(e.addr)});
            end
          end
          if (gnt) begin
            lat = (mode <= 1) ? 1 : $urandom_range(1, 4);
            due = cyc + lat;
            if (due <= last_due) begin
              due = last_due + 1;
            end
            last_due = due;
            e.addr  = m_fetch_pc;
            e.due   = due;
            e.stale = 1'b0;
            pend.push_back(e);
            m_fetch_pc = m_fetch_pc + 32'd4;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
